// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the control unit: loadable program memory plus PC.
// Each word is held on instr for exactly the number of edges the CU needs to retire it.
module instr_fetch #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [PC_BITS-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   instr_count
);

    localparam int DEPTH  = 1 << PC_BITS;
    localparam int HOLD_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [HOLD_W-1:0]      hold, hold_nxt;
    logic [INSTR_WIDTH-1:0] instr_nxt;
    logic [PC_BITS-1:0]     pc_nxt;
    logic [CNT_WIDTH-1:0]   count_nxt;

    logic [INSTR_WIDTH-1:0] imem [0:DEPTH-1];
    logic                   mem_we;
    logic [INSTR_WIDTH-1:0] fetch0;
    logic [PC_BITS-1:0]     next_addr;
    logic [INSTR_WIDTH-1:0] next_word;

    // Number of CU edges needed per instruction type; type 00 is the halt word.
    function automatic logic [HOLD_W-1:0] beats_of(input logic [INSTR_WIDTH-1:0] w);
        case (w[INSTR_WIDTH-1 -: 2])
            2'b01:   beats_of = HOLD_W'(3);
            2'b10:   beats_of = HOLD_W'(4);
            2'b11:   beats_of = HOLD_W'(3);
            default: beats_of = HOLD_W'(0);
        endcase
    endfunction

    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] w);
        is_halt = (w[INSTR_WIDTH-1 -: 2] == 2'b00);
    endfunction

    // Writes are locked out while running so the fetched program stays stable.
    assign mem_we = prog_we && (state != RUN);

    // Write-first bypass: a same-edge write to address 0 is what start fetches.
    assign fetch0    = (mem_we && (prog_addr == '0)) ? prog_data : imem[0];
    assign next_addr = pc + PC_BITS'(1);
    assign next_word = imem[next_addr];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            imem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_nxt = state;
        instr_nxt = instr;
        pc_nxt    = pc;
        hold_nxt  = hold;
        count_nxt = instr_count;

        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_nxt    = '0;
                    count_nxt = '0;
                    if (is_halt(fetch0)) begin
                        state_nxt = HALT;
                        instr_nxt = '0;
                        hold_nxt  = '0;
                    end else begin
                        // One extra edge covers the CU's RESET->DECODE step.
                        state_nxt = RUN;
                        instr_nxt = fetch0;
                        hold_nxt  = beats_of(fetch0) + HOLD_W'(1);
                    end
                end
            end

            RUN: begin
                if (hold > HOLD_W'(1)) begin
                    hold_nxt = hold - HOLD_W'(1);
                end else begin
                    count_nxt = instr_count + CNT_WIDTH'(1);
                    if (pc == {PC_BITS{1'b1}}) begin
                        // End of memory: stop rather than wrap the PC.
                        state_nxt = HALT;
                        instr_nxt = '0;
                        hold_nxt  = '0;
                    end else begin
                        pc_nxt = next_addr;
                        if (is_halt(next_word)) begin
                            state_nxt = HALT;
                            instr_nxt = '0;
                            hold_nxt  = '0;
                        end else begin
                            instr_nxt = next_word;
                            hold_nxt  = beats_of(next_word);
                        end
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                instr_nxt = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr       <= '0;
            pc          <= '0;
            hold        <= '0;
            instr_count <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            instr       <= instr_nxt;
            pc          <= pc_nxt;
            hold        <= hold_nxt;
            instr_count <= count_nxt;
            busy        <= (state_nxt == RUN);
            halted      <= (state_nxt == HALT);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic,
// compared every cycle against a trace-building reference model.
module tb_instr_fetch;

    localparam int IW    = 20;
    localparam int PB    = 5;
    localparam int CW    = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          prog_we = 1'b0;
    logic [PB-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic [IW-1:0] instr;
    logic [PB-1:0] pc;
    logic          busy;
    logic          halted;
    logic [CW-1:0] instr_count;

    instr_fetch #(.INSTR_WIDTH(IW), .PC_BITS(PB), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .instr      (instr),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [PB-1:0] pc;
        logic [CW-1:0] cnt;
        logic          busy;
        logic          halted;
    } snap_t;

    int            total = 0;
    int            bad = 0;
    snap_t         cur;
    snap_t         trace[$];
    logic [IW-1:0] ref_mem [0:DEPTH-1];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int beats(input logic [IW-1:0] w);
        case (w[IW-1 -: 2])
            2'b01:   beats = 3;
            2'b10:   beats = 4;
            2'b11:   beats = 3;
            default: beats = 0;
        endcase
    endfunction

    // The whole visible run after a start, one entry per clock edge.
    task automatic buildTrace();
        int c;
        int n;
        logic [IW-1:0] w;
        trace.delete();
        c = 0;
        for (int p = 0; p < DEPTH; p++) begin
            w = ref_mem[p];
            if (w[IW-1 -: 2] == 2'b00) begin
                trace.push_back('{'0, PB'(p), CW'(c), 1'b0, 1'b1});
                return;
            end
            n = beats(w) + ((p == 0) ? 1 : 0);
            for (int k = 0; k < n; k++) begin
                trace.push_back('{w, PB'(p), CW'(c), 1'b1, 1'b0});
            end
            c = (c + 1) % (1 << CW);
        end
        trace.push_back('{'0, PB'(DEPTH - 1), CW'(c), 1'b0, 1'b1});
    endtask

    task automatic modelEdge(input logic r, input logic s, input logic we,
                             input logic [PB-1:0] a, input logic [IW-1:0] d);
        if (r) begin
            cur = '0;
            trace.delete();
        end else if (cur.busy) begin
            if (trace.size() > 0) cur = trace.pop_front();
        end else begin
            if (we) ref_mem[a] = d;
            if (s) begin
                buildTrace();
                cur = trace.pop_front();
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic we,
                                 input logic [PB-1:0] a, input logic [IW-1:0] d);
        rst       = r;
        start     = s;
        prog_we   = we;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        modelEdge(r, s, we, a, d);
        #1;
        checkOutput("instr", 32'(instr), 32'(cur.instr));
        checkOutput("pc", 32'(pc), 32'(cur.pc));
        checkOutput("busy", 32'(busy), 32'(cur.busy));
        checkOutput("halted", 32'(halted), 32'(cur.halted));
        checkOutput("count", 32'(instr_count), 32'(cur.cnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [1:0]    ty;
        logic [IW-1:0] rd;
        cur = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);

        // End of memory: every word is a 3-beat op
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, PB'(i), 20'h51002);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        idle(110);
        checkOutput("eom_pc", 32'(pc), 32'd31);
        checkOutput("eom_count", 32'(instr_count), 32'd32);
        checkOutput("eom_halted", 32'(halted), 32'd1);

        // Mixed program
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 20'h51002);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd1, 20'hA4030);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd2, 20'hC4030);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 20'h00000);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        idle(14);
        checkOutput("mixed_pc", 32'(pc), 32'd3);
        checkOutput("mixed_count", 32'(instr_count), 32'd3);

        // Write gating: ignored while running, honoured in HALT
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd1, 20'hC4030);
        idle(14);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd1, 20'h7F00F);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        idle(14);

        // Reset mid-run, then restart from intact memory
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        checkOutput("rst_instr", 32'(instr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        idle(14);
        checkOutput("restart_count", 32'(instr_count), 32'd3);

        // Same-edge write and start from IDLE
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd0, 20'hA0010);
        checkOutput("wfirst_instr", 32'(instr), 32'hA0010);
        idle(20);

        // Empty program
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 20'h00000);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
        checkOutput("empty_halted", 32'(halted), 32'd1);
        idle(3);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            ty = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            rd = {ty, 18'($urandom)};
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) == 0), PB'($urandom), rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
